// File: rtl/ddr4_ddrphy_pkg.sv
// rtl/ddr4_ddrphy_pkg.sv - state encoding and default constants for the DDR4 PHY read-data aligner
package ddr4_ddrphy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_SLIP   = 3'd4,
        ST_MOVE   = 3'd5,
        ST_DONE   = 3'd6,
        ST_FAIL   = 3'd7
    } rx_align_state_t;

    localparam logic [3:0] DEF_TRAIN_PATTERN = 4'b0011;
    localparam int         DEF_MATCH_CYCLES  = 16;
    localparam int         DEF_SETTLE_CYCLES = 8;
    localparam int         DEF_MAX_TAPS      = 128;
    localparam int         WIN_CNT_W         = 16;

endpackage

// File: rtl/ddr4_ddrphy_rx_win_cnt.sv
// rtl/ddr4_ddrphy_rx_win_cnt.sv - shared settle/match window counter with load, enable and terminal count
module ddr4_ddrphy_rx_win_cnt
    import ddr4_ddrphy_pkg::*;
#(
    parameter int W = WIN_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // tc marks the enabled cycle that completes the window of 'limit' counts
    assign tc = en && (cnt == (limit - W'(1)));

endmodule

// File: rtl/ddr4_ddrphy_rx_align.sv
// rtl/ddr4_ddrphy_rx_align.sv - read-training bit-slip/delay-tap aligner; DDR4_RX_ALIGN_DBG_EN adds debug ports
module ddr4_ddrphy_rx_align
    import ddr4_ddrphy_pkg::*;
#(
    parameter logic [3:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int         MATCH_CYCLES  = DEF_MATCH_CYCLES,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int         MAX_TAPS      = DEF_MAX_TAPS
) (
    input  logic       FAB_CLK,
    input  logic       RX_SYNC_RST,
    input  logic       TRAIN_START,
    input  logic [3:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       RX_BIT_SLIP,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic [1:0] SLIP_COUNT,
    output logic [7:0] DELAY_TAPS,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [3:0] RX_DATA_OUT,
    output logic       RX_DATA_OUT_VALID
`ifdef DDR4_RX_ALIGN_DBG_EN
    ,
    output logic [2:0]  DBG_STATE,
    output logic [15:0] DBG_MISMATCH_CNT
`endif
);

    localparam logic [WIN_CNT_W-1:0] MATCH_LIM  = WIN_CNT_W'(MATCH_CYCLES);
    localparam logic [WIN_CNT_W-1:0] SETTLE_LIM = WIN_CNT_W'(SETTLE_CYCLES);
    localparam logic [7:0]           LAST_TAP   = 8'(MAX_TAPS - 1);

    rx_align_state_t        state, state_d;
    logic                   win_load, win_en, win_tc;
    logic [WIN_CNT_W-1:0]   win_limit;
    logic                   match, move_ok;

    assign match     = (RX_DATA == TRAIN_PATTERN);
    assign move_ok   = !DELAY_LINE_OUT_OF_RANGE && (DELAY_TAPS != LAST_TAP);
    assign win_limit = (state == ST_CHECK) ? MATCH_LIM : SETTLE_LIM;

    ddr4_ddrphy_rx_win_cnt #(.W(WIN_CNT_W)) u_win_cnt (
        .clk   (FAB_CLK),
        .rst   (RX_SYNC_RST),
        .load  (win_load),
        .en    (win_en),
        .limit (win_limit),
        .tc    (win_tc)
    );

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The window counter is held clear everywhere except while it is timing a settle or match run
    always_comb begin
        state_d  = state;
        win_load = 1'b1;
        win_en   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (TRAIN_START) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_SETTLE;
            ST_SETTLE: begin
                win_en   = 1'b1;
                win_load = win_tc;
                if (win_tc) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                win_en   = match;
                win_load = !match;
                if (!match)      state_d = ST_SLIP;
                else if (win_tc) state_d = ST_DONE;
            end
            ST_SLIP: state_d = (SLIP_COUNT == 2'd3) ? ST_MOVE : ST_SETTLE;
            ST_MOVE: state_d = move_ok ? ST_SETTLE : ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    // Load/slip pulses coincide with their state; the move pulse follows MOVE because
    // the out-of-range flag can only be judged there, which also keeps slip and move apart
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            RX_BIT_SLIP          <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            SLIP_COUNT           <= 2'd0;
            DELAY_TAPS           <= 8'd0;
            TRAIN_DONE           <= 1'b0;
            TRAIN_ERR            <= 1'b0;
            RX_DATA_OUT          <= 4'd0;
            RX_DATA_OUT_VALID    <= 1'b0;
        end else begin
            RX_DATA_OUT          <= RX_DATA;
            DELAY_LINE_DIRECTION <= 1'b1;
            DELAY_LINE_LOAD      <= (state_d == ST_LOAD);
            RX_BIT_SLIP          <= (state_d == ST_SLIP);
            DELAY_LINE_MOVE      <= (state == ST_MOVE) && move_ok;
            TRAIN_DONE           <= (state_d == ST_DONE);
            TRAIN_ERR            <= (state_d == ST_FAIL);
            RX_DATA_OUT_VALID    <= (state_d == ST_DONE);
            if (state_d == ST_LOAD) begin
                SLIP_COUNT <= 2'd0;
                DELAY_TAPS <= 8'd0;
            end else if (state == ST_SLIP) begin
                SLIP_COUNT <= SLIP_COUNT + 2'd1;
            end else if ((state == ST_MOVE) && move_ok) begin
                DELAY_TAPS <= DELAY_TAPS + 8'd1;
            end
        end
    end

`ifdef DDR4_RX_ALIGN_DBG_EN
    assign DBG_STATE = state;

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST || (state == ST_LOAD)) begin
            DBG_MISMATCH_CNT <= 16'd0;
        end else if ((state == ST_CHECK) && !match && (DBG_MISMATCH_CNT != 16'hFFFF)) begin
            DBG_MISMATCH_CNT <= DBG_MISMATCH_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr4_ddrphy_rx_align.sv
// tb/tb_ddr4_ddrphy_rx_align.sv - scoreboard bench with an IOD channel model for ddr4_ddrphy_rx_align
module tb_ddr4_ddrphy_rx_align;

    localparam logic [3:0] PAT      = 4'b0011;
    localparam int         MAX_TAPS = 128;
    localparam int EV_LOAD = 0, EV_SLIP = 1, EV_MOVE = 2, EV_DONE = 3, EV_FAIL = 4;

    logic       FAB_CLK = 1'b0;
    logic       RX_SYNC_RST, TRAIN_START, DELAY_LINE_OUT_OF_RANGE;
    logic [3:0] RX_DATA;
    logic       RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic [1:0] SLIP_COUNT;
    logic [7:0] DELAY_TAPS;
    logic       TRAIN_DONE, TRAIN_ERR, RX_DATA_OUT_VALID;
    logic [3:0] RX_DATA_OUT;
`ifdef DDR4_RX_ALIGN_DBG_EN
    logic [2:0]  DBG_STATE;
    logic [15:0] DBG_MISMATCH_CNT;
`endif

    ddr4_ddrphy_rx_align dut (
        .FAB_CLK(FAB_CLK), .RX_SYNC_RST(RX_SYNC_RST), .TRAIN_START(TRAIN_START),
        .RX_DATA(RX_DATA), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .RX_BIT_SLIP(RX_BIT_SLIP), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .SLIP_COUNT(SLIP_COUNT), .DELAY_TAPS(DELAY_TAPS), .TRAIN_DONE(TRAIN_DONE),
        .TRAIN_ERR(TRAIN_ERR), .RX_DATA_OUT(RX_DATA_OUT), .RX_DATA_OUT_VALID(RX_DATA_OUT_VALID)
`ifdef DDR4_RX_ALIGN_DBG_EN
        , .DBG_STATE(DBG_STATE), .DBG_MISMATCH_CNT(DBG_MISMATCH_CNT)
`endif
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int kind;
        int taps;
        int slips;
        int lat;
        int mism;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, start_cyc = 0;
    logic rst_q = 1'b0;
    logic [3:0] exp_out = 4'd0;
    bit   started = 0, prev_pulse = 0, prev_done = 0, prev_err = 0, in_done = 0;

    // channel configuration, set by the stimulus before each training run
    int good_tap = 0, good_rot = 0, oor_tap = 1000;
    bit zero = 0, glitch = 0, ignore_slip = 0;

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] p, input int r);
        logic [3:0] o;
        for (int i = 0; i < 4; i++) o[(i + r) % 4] = p[i];
        return o;
    endfunction

    function automatic void push(input int kind, input int taps, input int slips, input int lat, input int mism);
        ev_t e;
        e.kind = kind; e.taps = taps; e.slips = slips; e.lat = lat; e.mism = mism;
        exp_q.push_back(e);
    endfunction

    always @(posedge FAB_CLK) begin
        cyc     <= cyc + 1;
        rst_q   <= RX_SYNC_RST;
        exp_out <= RX_SYNC_RST ? 4'd0 : RX_DATA;
    end

    // IOD model: reacts to the aligner's pulses; data is correct only at/after good_tap with the right rotation
    initial begin
        int iod_tap, iod_rot, k;
        logic [3:0] d;
        iod_tap = 0; iod_rot = 0; k = 0;
        RX_DATA = 4'd0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        forever begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_LOAD) begin iod_tap = 0; iod_rot = 0; k = 0; end
            else k++;
            if (RX_BIT_SLIP && !ignore_slip) iod_rot = (iod_rot + 1) % 4;
            if (DELAY_LINE_MOVE) iod_tap++;
            DELAY_LINE_OUT_OF_RANGE = (iod_tap >= oor_tap);
            if (zero) d = 4'd0;
            else if (iod_tap >= good_tap) d = rotl(PAT, (iod_rot - good_rot + 4) % 4);
            else begin
                d = 4'($urandom);
                if (d == PAT) d = ~PAT;
            end
            if (glitch && k == 24) d = PAT ^ 4'b0100;
            RX_DATA = d;
        end
    end

    task automatic take(input int kind);
        ev_t e;
        int act;
        if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk(kind == e.kind, "event_kind", kind, e.kind);
            if (kind == EV_DONE || kind == EV_FAIL) begin
                act = cyc - start_cyc - 1;
                chk(int'(DELAY_TAPS) == e.taps, "final_taps", int'(DELAY_TAPS), e.taps);
                chk(int'(SLIP_COUNT) == e.slips, "final_slip_count", int'(SLIP_COUNT), e.slips);
                chk(act >= e.lat - 1 && act <= e.lat + 1, "latency", act, e.lat);
`ifdef DDR4_RX_ALIGN_DBG_EN
                chk(int'(DBG_MISMATCH_CNT) == e.mism, "dbg_mismatch_cnt", int'(DBG_MISMATCH_CNT), e.mism);
`endif
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse or a done/error edge
    always @(negedge FAB_CLK) begin
        int np;
        if (rst_q) begin
            chk({RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, TRAIN_DONE,
                 TRAIN_ERR, RX_DATA_OUT_VALID} == 7'd0, "reset_flags",
                int'({RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, TRAIN_DONE,
                      TRAIN_ERR, RX_DATA_OUT_VALID}), 0);
            chk({SLIP_COUNT, DELAY_TAPS, RX_DATA_OUT} == 14'd0, "reset_counters",
                int'({SLIP_COUNT, DELAY_TAPS, RX_DATA_OUT}), 0);
`ifdef DDR4_RX_ALIGN_DBG_EN
            chk(DBG_STATE == 3'd0, "reset_dbg_state", int'(DBG_STATE), 0);
`endif
            prev_pulse = 0; prev_done = 0; prev_err = 0; in_done = 0;
        end else if (started) begin
            np = int'(RX_BIT_SLIP) + int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE);
            chk(np <= 1, "pulse_exclusive", np, 1);
            chk(!(prev_pulse && np != 0), "pulse_spacing", np, 0);
            chk(RX_DATA_OUT == exp_out, "rx_data_out", int'(RX_DATA_OUT), int'(exp_out));
            chk(DELAY_LINE_DIRECTION == 1'b1, "direction", int'(DELAY_LINE_DIRECTION), 1);
            if (DELAY_LINE_LOAD) begin take(EV_LOAD); in_done = 0; end
            if (RX_BIT_SLIP) take(EV_SLIP);
            if (DELAY_LINE_MOVE) take(EV_MOVE);
            if (TRAIN_DONE && !prev_done) begin take(EV_DONE); in_done = 1; end
            if (TRAIN_ERR && !prev_err) take(EV_FAIL);
            chk(RX_DATA_OUT_VALID == in_done, "data_valid", int'(RX_DATA_OUT_VALID), int'(in_done));
            prev_pulse = (np != 0);
            prev_done  = TRAIN_DONE;
            prev_err   = TRAIN_ERR;
        end
    end

    task automatic pulse_start();
        @(negedge FAB_CLK);
        start_cyc   = cyc;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge FAB_CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk(1'b0, "timeout_pending_events", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Reference: walk taps and rotations from tap 0; every miss costs settle+check+slip
    task automatic run_train(input int gt, input int gr, input int ot, input bit z, input bit gl, input int ign_at);
        int t = 0, s = 0, slips = 0, moves = 0;
        bit fin = 0;
        good_tap = gt; good_rot = gr; oor_tap = ot; zero = z; glitch = gl; ignore_slip = gl;
        push(EV_LOAD, 0, 0, 0, 0);
        if (gl) begin
            push(EV_SLIP, 0, 0, 0, 0);
            push(EV_DONE, 0, 1, 1 + 8 + 16 + 1 + 8 + 16, 1);
        end else begin
            while (!fin) begin
                if (!z && t >= gt && s == gr) begin
                    push(EV_DONE, t, s, 1 + 10 * slips + moves + 8 + 16, slips);
                    fin = 1;
                end else begin
                    push(EV_SLIP, 0, 0, 0, 0);
                    slips++;
                    if (s == 3) begin
                        s = 0;
                        if (t >= ot || t == MAX_TAPS - 1) begin
                            push(EV_FAIL, t, 0, 1 + 10 * slips + moves + 1, slips);
                            fin = 1;
                        end else begin
                            push(EV_MOVE, 0, 0, 0, 0);
                            moves++;
                            t++;
                        end
                    end else begin
                        s++;
                    end
                end
            end
        end
        pulse_start();
        if (ign_at > 0) begin
            repeat (ign_at) @(negedge FAB_CLK);
            TRAIN_START = 1'b1;
            @(negedge FAB_CLK);
            TRAIN_START = 1'b0;
        end
        wait_drain(20000);
        repeat (4) @(negedge FAB_CLK);
        glitch = 0; ignore_slip = 0;
    endtask

    task automatic run_reset_mid_settle();
        good_tap = 5; good_rot = 0; oor_tap = 1000; zero = 0;
        push(EV_LOAD, 0, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 4; i++) push(EV_SLIP, 0, 0, 0, 0);
            push(EV_MOVE, 0, 0, 0, 0);
        end
        pulse_start();
        wait_drain(2000);
        repeat (3) @(negedge FAB_CLK);
        chk(DELAY_TAPS == 8'd3, "taps_before_reset", int'(DELAY_TAPS), 3);
        RX_SYNC_RST = 1'b1;
        @(negedge FAB_CLK);
        RX_SYNC_RST = 1'b0;
        repeat (40) @(negedge FAB_CLK);
        chk({TRAIN_DONE, TRAIN_ERR} == 2'b00, "idle_after_reset", int'({TRAIN_DONE, TRAIN_ERR}), 0);
        chk(DELAY_TAPS == 8'd0, "taps_after_reset", int'(DELAY_TAPS), 0);
    endtask

    initial begin
        RX_SYNC_RST = 1'b1;
        TRAIN_START = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        RX_SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        started = 1;
        run_train(0, 0, 1000, 0, 0, 13);
        run_train(0, 2, 1000, 0, 0, 0);
        run_train(5, 0, 1000, 0, 0, 0);
        run_train(0, 0, 10, 1, 0, 0);
        run_train(0, 0, 1000, 0, 1, 0);
        run_reset_mid_settle();
        for (int i = 0; i < 4; i++)
            run_train(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1000, 0, 0, 0);
        run_train(0, 0, 1000, 1, 0, 0);
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
